reg_master: RTL and testbench

REG_MASTER -- requirements
Module: reg_master

---
 rtl/reg_master.sv | 192 +++++++++++++++++++
 tb/tb_reg_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_master.sv
// Register-bus master: turns one valid/ready command into a single write or read
// strobe on a simple register port and returns a valid/ready response.
module reg_master #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  reg_wren,
    output logic [ADDR_WIDTH-1:0] reg_wraddr,
    output logic [DATA_WIDTH-1:0] reg_wrdata,
    output logic                  reg_rden,
    output logic [ADDR_WIDTH-1:0] reg_rdaddr,
    input  logic [DATA_WIDTH-1:0] reg_rddata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // The counter is loaded with L-1 so that WAIT lasts exactly L cycles.
    localparam logic [3:0] WAIT_LOAD = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;
    localparam bit         NO_WAIT   = (RD_LATENCY == 0);

    state_t                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    lat_write_q, lat_write_d;
    logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0]   lat_wdata_q, lat_wdata_d;
    logic                    capture_s;
    logic                    accept_s;

    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    reg_wren_q, reg_wren_d;
    logic [ADDR_WIDTH-1:0]   reg_wraddr_q, reg_wraddr_d;
    logic [DATA_WIDTH-1:0]   reg_wrdata_q, reg_wrdata_d;
    logic                    reg_rden_q, reg_rden_d;
    logic [ADDR_WIDTH-1:0]   reg_rdaddr_q, reg_rdaddr_d;

    assign accept_s = cmd_valid & cmd_ready_q;

    // State, latched command, wait counter and all output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 4'd0;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            reg_wren_q   <= 1'b0;
            reg_wraddr_q <= '0;
            reg_wrdata_q <= '0;
            reg_rden_q   <= 1'b0;
            reg_rdaddr_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_write_q  <= rsp_write_d;
            rsp_rdata_q  <= rsp_rdata_d;
            reg_wren_q   <= reg_wren_d;
            reg_wraddr_q <= reg_wraddr_d;
            reg_wrdata_q <= reg_wrdata_d;
            reg_rden_q   <= reg_rden_d;
            reg_rdaddr_q <= reg_rdaddr_d;
        end
    end

    // Next-state logic, command latching and read-data capture timing.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        lat_write_d = lat_write_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        capture_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    lat_write_d = cmd_write;
                    lat_addr_d  = cmd_addr;
                    lat_wdata_d = cmd_wdata;
                    state_d     = cmd_write ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            READ: begin
                if (NO_WAIT) begin
                    capture_s = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    capture_s = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so every port is a flop.
    always_comb begin
        cmd_ready_d  = (state_d == IDLE);
        rsp_valid_d  = (state_d == RESP);
        reg_wren_d   = (state_d == WRITE);
        reg_rden_d   = (state_d == READ);
        reg_wraddr_d = reg_wraddr_q;
        reg_wrdata_d = reg_wrdata_q;
        reg_rdaddr_d = reg_rdaddr_q;
        rsp_write_d  = rsp_write_q;
        rsp_rdata_d  = rsp_rdata_q;
        if (state_d == WRITE) begin
            reg_wraddr_d = lat_addr_d;
            reg_wrdata_d = lat_wdata_d;
        end else begin
            reg_wraddr_d = reg_wraddr_q;
            reg_wrdata_d = reg_wrdata_q;
        end
        // Read address stays put from the strobe cycle until the data is captured.
        if (state_d == READ) begin
            reg_rdaddr_d = lat_addr_d;
        end else begin
            reg_rdaddr_d = reg_rdaddr_q;
        end
        if (state_q == WRITE) begin
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
        end else if (capture_s) begin
            rsp_write_d = 1'b0;
            rsp_rdata_d = reg_rddata;
        end else begin
            rsp_write_d = rsp_write_q;
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign reg_wren   = reg_wren_q;
    assign reg_wraddr = reg_wraddr_q;
    assign reg_wrdata = reg_wrdata_q;
    assign reg_rden   = reg_rden_q;
    assign reg_rdaddr = reg_rdaddr_q;

endmodule

// File: tb/tb_reg_master.sv
// Bench for reg_master: a zero-latency instance with a combinational 4-entry
// register file and an RD_LATENCY=3 instance with a 3-cycle delayed responder.
module tb_reg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_cmd_valid, a_cmd_ready, a_cmd_write, a_rsp_valid, a_rsp_ready, a_rsp_write;
    logic [1:0]  a_cmd_addr, a_wraddr, a_rdaddr;
    logic [31:0] a_cmd_wdata, a_rsp_rdata, a_wrdata, a_rddata;
    logic        a_wren, a_rden;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid, b_rsp_ready, b_rsp_write;
    logic [1:0]  b_cmd_addr, b_wraddr, b_rdaddr;
    logic [31:0] b_cmd_wdata, b_rsp_rdata, b_wrdata, b_rddata;
    logic        b_wren, b_rden;

    reg_master #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .RD_LATENCY(0)) dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
        .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_write(a_rsp_write),
        .rsp_rdata(a_rsp_rdata),
        .reg_wren(a_wren), .reg_wraddr(a_wraddr), .reg_wrdata(a_wrdata),
        .reg_rden(a_rden), .reg_rdaddr(a_rdaddr), .reg_rddata(a_rddata)
    );

    reg_master #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_write(b_rsp_write),
        .rsp_rdata(b_rsp_rdata),
        .reg_wren(b_wren), .reg_wraddr(b_wraddr), .reg_wrdata(b_wrdata),
        .reg_rden(b_rden), .reg_rdaddr(b_rdaddr), .reg_rddata(b_rddata)
    );

    // Register responders (not reset, so contents survive a master reset).
    logic [31:0] mem_a [4];
    logic [31:0] mem_b [4];
    logic [31:0] b_d1, b_d2, b_d3;
    assign a_rddata = mem_a[a_rdaddr];
    assign b_rddata = b_d3;

    always @(posedge clk) begin
        if (a_wren) mem_a[a_wraddr] <= a_wrdata;
        if (b_wren) mem_b[b_wraddr] <= b_wrdata;
        b_d1 <= mem_b[b_rdaddr];
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end

    int checks = 0;
    int errors = 0;
    int strobes_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        w;
        logic [31:0] d;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    // Scoreboard and strobe monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (a_rsp_valid && a_rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", {31'd0, a_rsp_valid}, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("sb_rsp_write", {31'd0, a_rsp_write}, {31'd0, mon_e.w});
                        chk("sb_rsp_rdata", a_rsp_rdata, mon_e.d);
                    end
                end
                if (a_wren || a_rden) strobes_a++;
                if ((a_wren && a_rden) || (b_wren && b_rden)) begin
                    chk("strobe_overlap", 32'd1, 32'd0);
                end
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // One full command on instance A; entered and left just after a rising edge.
    task automatic cmd_a(input logic w, input logic [1:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
        int n;
        a_cmd_valid = 1'b1; a_cmd_write = w; a_cmd_addr = addr; a_cmd_wdata = wd;
        a_rsp_ready = 1'b1;
        exp_q.push_back(rsp_t'({w, (w ? 32'd0 : exp_rd)}));
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, a_cmd_ready}, 32'd1);
        to_drive();
        a_cmd_valid = 1'b0;
        @(negedge clk);
        chk("wren_pulse", {31'd0, a_wren}, {31'd0, w});
        chk("rden_pulse", {31'd0, a_rden}, {31'd0, ~w});
        if (w) begin
            chk("wraddr", {30'd0, a_wraddr}, {30'd0, addr});
            chk("wrdata", a_wrdata, wd);
        end else begin
            chk("rdaddr", {30'd0, a_rdaddr}, {30'd0, addr});
        end
        n = 1;
        while (!a_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", n, 32'd2);
        to_drive();
        @(negedge clk);
        chk("rsp_valid_drop", {31'd0, a_rsp_valid}, 32'd0);
        chk("cmd_ready_back", {31'd0, a_cmd_ready}, 32'd1);
        to_drive();
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int n;
        int k;
        int acc[4];
        int snap;
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
        n = 0; k = 0; snap = 0; acc[0] = 0;
    end

    initial begin
        int n;
        int k;
        int snap;
        int acc[4];
        vecs[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 2'd2, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 2'd0, 32'hA5A5A5A5, 32'h0};
        vecs[3] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
        vecs[4] = '{1'b1, 2'd1, 32'h00000001, 32'h0};
        vecs[5] = '{1'b0, 2'd0, 32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1'b0, 2'd3, 32'h0,        32'hFFFFFFFF};
        vecs[7] = '{1'b0, 2'd1, 32'h0,        32'h00000001};

        rst = 1'b1;
        a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_addr = 2'd0; a_cmd_wdata = 32'd0; a_rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = 2'd0; b_cmd_wdata = 32'd0; b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, a_cmd_ready}, 32'd0);
        chk("rst_outputs", {a_rsp_valid, a_rsp_write, a_wren, a_rden, a_wraddr, a_rdaddr}, 32'd0);
        chk("rst_rdata", a_rsp_rdata | a_wrdata, 32'd0);
        to_drive();
        rst = 1'b0;
        to_drive();
        @(negedge clk);
        chk("cmd_ready_after_rst", {31'd0, a_cmd_ready}, 32'd1);
        to_drive();

        for (int i = 0; i < 8; i++) begin
            cmd_a(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
        end

        // Response stall: rsp_ready low for 10 cycles while cmd_valid pulses.
        a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 2'd2; a_rsp_ready = 1'b0;
        exp_q.push_back(rsp_t'({1'b0, 32'hDEADBEEF}));
        to_drive();
        a_cmd_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_latency", n, 32'd2);
        to_drive();
        snap = strobes_a;
        for (int i = 0; i < 10; i++) begin
            a_cmd_valid = i[0]; a_cmd_write = 1'b1; a_cmd_addr = 2'd0; a_cmd_wdata = 32'h00000BAD;
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
            chk("stall_rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
            chk("stall_cmd_ready", {31'd0, a_cmd_ready}, 32'd0);
            to_drive();
        end
        chk("stall_no_strobes", strobes_a - snap, 32'd0);
        a_cmd_valid = 1'b0; a_rsp_ready = 1'b1;
        to_drive();
        @(negedge clk);
        chk("stall_release", {31'd0, a_rsp_valid}, 32'd0);
        chk("stall_ignored_write", mem_a[0], 32'hA5A5A5A5);
        to_drive();

        // Reset in the cycle after accepting a write drops it.
        snap = strobes_a;
        a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 2'd0; a_cmd_wdata = 32'h00000055;
        @(posedge clk);
        #1;
        rst = 1'b1;
        a_cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_wren", {31'd0, a_wren}, 32'd0);
        chk("rst_mid_cmd_ready", {31'd0, a_cmd_ready}, 32'd0);
        to_drive();
        rst = 1'b0;
        to_drive();
        @(negedge clk);
        chk("rst_mid_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, a_cmd_ready}, 32'd1);
        chk("rst_mid_no_strobe", strobes_a - snap, 32'd0);
        to_drive();
        cmd_a(1'b0, 2'd0, 32'd0, 32'hA5A5A5A5);

        // Back-to-back writes with cmd_valid and rsp_ready held high.
        k = 0;
        a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_rsp_ready = 1'b1;
        a_cmd_addr = 2'd0; a_cmd_wdata = 32'h10000000;
        exp_q.push_back(rsp_t'({1'b1, 32'd0}));
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (a_cmd_ready) begin
                acc[k] = c;
                k++;
            end
            to_drive();
            if (k == 4) begin
                a_cmd_valid = 1'b0;
            end else if (a_cmd_addr != 2'(k)) begin
                a_cmd_addr = 2'(k);
                a_cmd_wdata = 32'h10000000 + 32'(k);
                exp_q.push_back(rsp_t'({1'b1, 32'd0}));
            end
        end
        chk("b2b_count", k, 32'd4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 32'd3);
        repeat (4) to_drive();
        for (int i = 0; i < 4; i++) chk("b2b_mem", mem_a[i], 32'h10000000 + 32'(i));

        // RD_LATENCY=3 instance: write then read address 1.
        b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 2'd1; b_cmd_wdata = 32'h12345678;
        b_rsp_ready = 1'b1;
        to_drive();
        b_cmd_valid = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat3_write_latency", n, 32'd2);
        chk("lat3_write_rsp", {b_rsp_write, b_rsp_rdata[30:0]}, 32'h80000000);
        to_drive();
        b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 2'd1;
        @(negedge clk);
        chk("lat3_cmd_ready", {31'd0, b_cmd_ready}, 32'd1);
        to_drive();
        b_cmd_valid = 1'b0;
        @(negedge clk);
        n = 1;
        chk("lat3_rden", {31'd0, b_rden}, 32'd1);
        chk("lat3_rdaddr", {30'd0, b_rdaddr}, 32'd1);
        while (!b_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n <= 4) begin
                chk("lat3_wait_rden", {31'd0, b_rden}, 32'd0);
                chk("lat3_wait_rdaddr", {30'd0, b_rdaddr}, 32'd1);
            end
        end
        chk("lat3_rsp_latency", n, 32'd5);
        chk("lat3_rsp_rdata", b_rsp_rdata, 32'h12345678);
        chk("lat3_rsp_write", {31'd0, b_rsp_write}, 32'd0);
        to_drive();
        @(negedge clk);
        chk("lat3_rsp_drop", {31'd0, b_rsp_valid}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
